imem_loader: RTL and testbench

- Boot-time program loader for the byte-addressed instruction memory (2**ADDRESS_WIDTH bytes; byte at addr+0 is the instruction MSB).
- Accepts a length-prefixed byte stream over a valid/ready interface, for example from the UART receiver.
- Writes the bytes to consecutive instruction-memory addresses starting at 0.
- Holds the CPU (PC/fetch stall) while loading and releases it when the load is complete.

---
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream into instruction memory.
// Holds the CPU until the image is written, then releases it.
module imem_loader #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int TIMEOUT       = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [7:0]               wr_data,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error,
  output logic [ADDRESS_WIDTH:0]   byte_count
);

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);
  localparam logic [31:0] MAX_LEN = 32'd1 << ADDRESS_WIDTH;

  typedef enum logic [2:0] {
    IDLE, HDR, LOAD, DONE, ERR
  } state_t;

  state_t state, state_d;

  logic [31:0]              len, len_d, len_next;
  logic [31:0]              count_next;
  logic [1:0]               hdr_cnt, hdr_cnt_d;
  logic [IW-1:0]            idle_cnt, idle_cnt_d;
  logic                     wr_en_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_d;
  logic [7:0]               wr_data_d;
  logic                     cpu_hold_d;
  logic                     done_d;
  logic                     error_d;
  logic [ADDRESS_WIDTH:0]   byte_count_d;
  logic                     take;

  assign rx_ready   = (state == HDR) || (state == LOAD);
  assign take       = rx_valid && rx_ready;
  assign len_next   = {len[23:0], rx_data};
  assign count_next = 32'(byte_count) + 32'd1;

  always_comb begin
    state_d      = state;
    len_d        = len;
    hdr_cnt_d    = hdr_cnt;
    idle_cnt_d   = idle_cnt;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    cpu_hold_d   = cpu_hold;
    done_d       = done;
    error_d      = error;
    byte_count_d = byte_count;

    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d      = HDR;
          cpu_hold_d   = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
          byte_count_d = '0;
          hdr_cnt_d    = '0;
          idle_cnt_d   = '0;
        end else if (state == DONE) begin
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end else if (state == ERR) begin
          error_d    = 1'b1;
          cpu_hold_d = 1'b1;
        end
      end
      HDR: begin
        if (take) begin
          len_d      = len_next;
          hdr_cnt_d  = hdr_cnt + 2'd1;
          idle_cnt_d = '0;
          if (hdr_cnt == 2'd3) begin
            if (len_next == 32'd0) begin
              state_d = DONE;
            end else if (len_next > MAX_LEN) begin
              state_d = ERR;
              error_d = 1'b1;
            end else begin
              state_d = LOAD;
            end
          end
        end
      end
      LOAD: begin
        if (take) begin
          wr_en_d      = 1'b1;
          wr_addr_d    = byte_count[ADDRESS_WIDTH-1:0];
          wr_data_d    = rx_data;
          byte_count_d = count_next[ADDRESS_WIDTH:0];
          idle_cnt_d   = '0;
          if (count_next == len) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // a consumed byte always beats the timeout on the same edge
    if (rx_ready && !take) begin
      if (idle_cnt == IDLE_MAX) begin
        state_d = ERR;
        error_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      len        <= '0;
      hdr_cnt    <= '0;
      idle_cnt   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      byte_count <= '0;
    end else begin
      state      <= state_d;
      len        <= len_d;
      hdr_cnt    <= hdr_cnt_d;
      idle_cnt   <= idle_cnt_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      cpu_hold   <= cpu_hold_d;
      done       <= done_d;
      error      <= error_d;
      byte_count <= byte_count_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: vector table of loads, write scoreboard,
// plus hand sequences for timeout and reset mid-load.
module tb_imem_loader;

  localparam int AW = 10;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   byte_count;

  imem_loader #(
    .ADDRESS_WIDTH(AW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error),
    .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  typedef struct {
    logic [31:0] len;
    int          gap;
    bit          exp_err;
  } vec_t;

  wr_t        sb[$];
  logic [7:0] bytes[$];
  logic [7:0] prog[8];
  vec_t       vecs[6];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // advance one clock and sample just after the edge; pop writes
  task automatic step();
    @(posedge clk);
    #1;
    if (wr_en === 1'b1) begin
      wr_t e;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data %0h, required none",
                 wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!acc && n < 50) begin
      acc = rx_ready;
      step();
      n++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_byte: byte %0h not accepted in 50 cycles", b);
    end
  endtask

  task automatic pulse_start();
    rx_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push_hdr(input logic [31:0] len);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = len >> (24 - 8 * i);
      bytes.push_back(t[7:0]);
    end
  endtask

  function automatic logic [7:0] pay(input logic [31:0] len, input int i);
    if (len == 32'd8) return prog[i];
    return 8'(i * 7 + 3);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    prog = '{8'h13, 8'h00, 8'h00, 8'h93, 8'h01, 8'h00, 8'h05, 8'h13};
    vecs[0] = '{32'd8,    0, 1'b0};
    vecs[1] = '{32'd8,    2, 1'b0};
    vecs[2] = '{32'd1025, 0, 1'b1};
    vecs[3] = '{32'd0,    0, 1'b0};
    vecs[4] = '{32'd1,    1, 1'b0};
    vecs[5] = '{32'd1024, 0, 1'b0};

    // reset, then idle with stray rx_valid
    step();
    step();
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_cpu_hold", 32'(cpu_hold), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_byte_count", 32'(byte_count), 0);
    check("rst_rx_ready", 32'(rx_ready), 0);
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (100) step();
    rx_valid = 1'b0;
    check("idle_cpu_hold", 32'(cpu_hold), 0);
    check("idle_rx_ready", 32'(rx_ready), 0);
    check("idle_byte_count", 32'(byte_count), 0);

    for (int v = 0; v < 6; v++) begin
      pulse_start();
      check("start_cpu_hold", 32'(cpu_hold), 1);
      check("start_done", 32'(done), 0);
      check("start_error", 32'(error), 0);
      check("start_byte_count", 32'(byte_count), 0);
      check("start_rx_ready", 32'(rx_ready), 1);
      bytes.delete();
      push_hdr(vecs[v].len);
      if (!vecs[v].exp_err) begin
        for (int i = 0; i < int'(vecs[v].len); i++) begin
          wr_t e;
          e.addr = AW'(i);
          e.data = pay(vecs[v].len, i);
          bytes.push_back(e.data);
          sb.push_back(e);
        end
      end
      for (int j = 0; j < bytes.size(); j++) begin
        send_byte(bytes[j]);
        if (vecs[v].gap > 0 && j < bytes.size() - 1) idle(vecs[v].gap);
      end
      if (vecs[v].exp_err) begin
        check("big_error", 32'(error), 1);
        check("big_cpu_hold", 32'(cpu_hold), 1);
        check("big_rx_ready", 32'(rx_ready), 0);
        check("big_done", 32'(done), 0);
        idle(3);
        check("big_error_hold", 32'(error), 1);
        check("big_cpu_hold2", 32'(cpu_hold), 1);
        check("big_byte_count", 32'(byte_count), 0);
      end else if (vecs[v].len == 32'd0) begin
        check("zero_done_pre", 32'(done), 0);
        check("zero_rx_ready", 32'(rx_ready), 0);
        step();
        check("zero_done", 32'(done), 1);
        check("zero_cpu_hold", 32'(cpu_hold), 0);
        check("zero_byte_count", 32'(byte_count), 0);
      end else begin
        check("last_wr_en", 32'(wr_en), 1);
        check("last_done", 32'(done), 0);
        check("last_cpu_hold", 32'(cpu_hold), 1);
        check("last_rx_ready", 32'(rx_ready), 0);
        step();
        check("fin_done", 32'(done), 1);
        check("fin_cpu_hold", 32'(cpu_hold), 0);
        check("fin_wr_en", 32'(wr_en), 0);
        check("fin_error", 32'(error), 0);
        check("fin_byte_count", 32'(byte_count), vecs[v].len);
        check("fin_rx_ready", 32'(rx_ready), 0);
      end
      rx_valid = 1'b0;
      check("writes_missing", sb.size(), 0);
    end

    // timeout after two payload bytes of a 4-byte load
    pulse_start();
    bytes.delete();
    push_hdr(32'd4);
    for (int i = 0; i < 2; i++) begin
      wr_t e;
      e.addr = AW'(i);
      e.data = prog[i];
      bytes.push_back(e.data);
      sb.push_back(e);
    end
    for (int j = 0; j < bytes.size(); j++) send_byte(bytes[j]);
    rx_valid = 1'b0;
    repeat (15) step();
    check("to_pre_error", 32'(error), 0);
    step();
    check("to_error", 32'(error), 1);
    check("to_cpu_hold", 32'(cpu_hold), 1);
    check("to_byte_count", 32'(byte_count), 2);
    check("to_rx_ready", 32'(rx_ready), 0);
    pulse_start();
    check("to_restart_error", 32'(error), 0);
    check("to_restart_rx_ready", 32'(rx_ready), 1);
    check("to_restart_cpu_hold", 32'(cpu_hold), 1);
    check("to_restart_byte_count", 32'(byte_count), 0);
    rst = 1'b0;
    step();
    rst = 1'b1;

    // reset after three payload bytes of an 8-byte load
    pulse_start();
    bytes.delete();
    push_hdr(32'd8);
    for (int i = 0; i < 3; i++) begin
      wr_t e;
      e.addr = AW'(i);
      e.data = prog[i];
      bytes.push_back(e.data);
      sb.push_back(e);
    end
    for (int j = 0; j < bytes.size(); j++) send_byte(bytes[j]);
    rst = 1'b0;
    start = 1'b1;
    rx_valid = 1'b1;
    step();
    check("mid_byte_count", 32'(byte_count), 0);
    check("mid_cpu_hold", 32'(cpu_hold), 0);
    check("mid_wr_en", 32'(wr_en), 0);
    check("mid_rx_ready", 32'(rx_ready), 0);
    check("mid_done", 32'(done), 0);
    step();
    check("mid_start_cpu_hold", 32'(cpu_hold), 0);
    check("mid_start_rx_ready", 32'(rx_ready), 0);
    rst = 1'b1;
    start = 1'b0;
    rx_valid = 1'b0;
    step();
    check("post_rst_rx_ready", 32'(rx_ready), 0);
    check("post_rst_cpu_hold", 32'(cpu_hold), 0);
    check("mid_writes_missing", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
